// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module : dsp_mac_sequencer
// Brief  : Streams LEN operand pairs into a DSP48A1 slice as a dot-product MAC
//          and captures the accumulated P as RESULT.
// Rev    : 1.0  initial release
// ============================================================================
module dsp_mac_sequencer #(
  parameter int         LEN_W     = 16,
  parameter int         MAC_LAT   = 3,
  parameter logic [7:0] OPM_FIRST = 8'h01,
  parameter logic [7:0] OPM_ACC   = 8'h09
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic [17:0]      IN_A,
  input  logic [17:0]      IN_B,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [47:0]      P_IN,
  output logic [17:0]      DSP_A,
  output logic [17:0]      DSP_B,
  output logic [7:0]       DSP_OPMODE,
  output logic             DSP_CEA,
  output logic             DSP_CEB,
  output logic             DSP_CEM,
  output logic             DSP_CEOPMODE,
  output logic             DSP_CEP,
  output logic [47:0]      RESULT,
  output logic             RESULT_VALID,
  output logic             BUSY
);

  localparam logic [LEN_W-1:0] C_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               first_pend_q, first_pend_d;
  logic [MAC_LAT:1]   tag_v_q, tag_v_d;
  logic [7:0]         opm_q, opm_d;
  logic [47:0]        result_q, result_d;
  logic               result_valid_q, result_valid_d;

  logic               w_accept;
  logic               w_first0;
  logic               w_first_at;
  logic [MAC_LAT:0]   w_stage_v;
  logic               w_drain_done;

  // The first flag only matters up to the stage that selects OPMODE.
  if (MAC_LAT > 2) begin : g_first_pipe
    logic [MAC_LAT-2:1] tag_f_q;
    logic [MAC_LAT-2:0] w_f_chain;
    assign w_f_chain  = {tag_f_q, w_first0};
    assign w_first_at = w_f_chain[MAC_LAT-2];
    always_ff @(posedge CLK) begin
      if (RST) tag_f_q <= '0;
      else     tag_f_q <= w_f_chain[MAC_LAT-3:0];
    end
  end else begin : g_first_direct
    assign w_first_at = w_first0;
  end

  always_comb begin
    w_accept     = IN_VALID && (state_q == S_RUN);
    w_first0     = w_accept && first_pend_q;
    w_stage_v    = {tag_v_q, w_accept};
    w_drain_done = tag_v_q[MAC_LAT] && !(|w_stage_v[MAC_LAT-1:0]);
    tag_v_d      = w_stage_v[MAC_LAT-1:0];

    opm_d = opm_q;
    if (w_stage_v[MAC_LAT-2]) opm_d = w_first_at ? OPM_FIRST : OPM_ACC;

    state_d        = state_q;
    cnt_d          = cnt_q;
    first_pend_d   = first_pend_q;
    result_d       = result_q;
    result_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (LEN != '0) begin
            state_d      = S_RUN;
            cnt_d        = LEN;
            first_pend_d = 1'b1;
          end else begin
            state_d        = S_DONE;
            result_d       = '0;
            result_valid_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (w_accept) begin
          cnt_d        = cnt_q - C_ONE;
          first_pend_d = 1'b0;
          if (cnt_q == C_ONE) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // No accepts happen here, so the oldest-only tag left is the last sample.
        if (w_drain_done) begin
          result_d       = P_IN;
          result_valid_d = 1'b1;
          state_d        = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      first_pend_q   <= 1'b0;
      tag_v_q        <= '0;
      opm_q          <= 8'h00;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      first_pend_q   <= first_pend_d;
      tag_v_q        <= tag_v_d;
      opm_q          <= opm_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign IN_READY     = (state_q == S_RUN);
  assign BUSY         = (state_q != S_IDLE);
  assign DSP_A        = IN_A;
  assign DSP_B        = IN_B;
  assign DSP_CEA      = w_accept;
  assign DSP_CEB      = w_accept;
  assign DSP_CEM      = 1'b1;
  assign DSP_CEOPMODE = 1'b1;
  assign DSP_CEP      = w_stage_v[MAC_LAT-1];
  assign DSP_OPMODE   = opm_d;
  assign RESULT       = result_q;
  assign RESULT_VALID = result_valid_q;

endmodule
`default_nettype wire
